// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the rv32i instruction fetch stage.
// Holds the fetch FSM state enum, instruction field positions and the NOP encoding.
package rv_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_e;

   localparam int OPCODE_LSB = 0;
   localparam int OPCODE_MSB = 6;
   localparam int F3_LSB     = 12;
   localparam int F3_MSB     = 14;
   localparam int F7_BIT     = 30;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: imem request/response, redirect from execute, decode handshake.
// master = fetch_unit side, slave = memory / execute / decode side.
interface fetch_unit_if;

   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [6:0]  op_code;
   logic [2:0]  f3;
   logic        f7;

   modport master (
      output imem_req_valid, imem_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  redirect, redirect_pc,
      output instr_valid, instr, instr_pc, op_code, f3, f7,
      input  instr_ready
   );

   modport slave (
      input  imem_req_valid, imem_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output redirect, redirect_pc,
      input  instr_valid, instr, instr_pc, op_code, f3, f7,
      output instr_ready
   );

endinterface

// File: rtl/fetch_unit_buffer.sv
// Single-entry instruction buffer: instr/pc register with load/clear and field slicing.
// Ports: clk, rst_n, i_load, i_clr, i_data, i_pc -> o_valid, o_instr, o_pc, o_op_code, o_f3, o_f7.
module fetch_buffer
   import rv_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic        i_clr,
   input  logic [31:0] i_data,
   input  logic [31:0] i_pc,
   output logic        o_valid,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc,
   output logic [6:0]  o_op_code,
   output logic [2:0]  o_f3,
   output logic        o_f7
);

   logic        r_valid;
   logic [31:0] r_instr;
   logic [31:0] r_pc;

   // Clearing only drops the valid flag; data is left as-is.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_instr <= '0;
         r_pc    <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_instr <= i_data;
         r_pc    <= i_pc;
      end else if (i_clr) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid   = r_valid;
   assign o_instr   = r_instr;
   assign o_pc      = r_pc;
   assign o_op_code = r_instr[OPCODE_MSB:OPCODE_LSB];
   assign o_f3      = r_instr[F3_MSB:F3_LSB];
   assign o_f7      = r_instr[F7_BIT];

endmodule

// File: rtl/fetch_unit.sv
// rv32i fetch stage: PC, imem valid/ready request, redirect with stale-response discard.
// Ports: clk, rst_n, bus (fetch_unit_if.master); parameter RESET_PC.
module fetch_unit
   import rv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic       clk,
   input  logic       rst_n,
   fetch_unit_if.master bus
);

   fetch_state_e r_state;
   fetch_state_e w_state_nxt;
   logic [31:0]  r_pc;
   logic [31:0]  w_pc_nxt;
   logic         r_discard;
   logic         w_discard_nxt;
   logic         w_load;
   logic         w_clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_pc      <= RESET_PC;
         r_discard <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_discard <= w_discard_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_discard_nxt = r_discard;
      w_load        = 1'b0;
      w_clr         = 1'b0;
      if (bus.redirect) begin
         w_pc_nxt = bus.redirect_pc & ~32'h3;
         w_clr    = 1'b1;
         unique case (r_state)
            IDLE: w_state_nxt = REQ;
            REQ: begin
               // Old-address request accepted this cycle: its reply is stale.
               if (bus.imem_req_ready) begin
                  w_state_nxt   = WAIT;
                  w_discard_nxt = 1'b1;
               end else begin
                  w_state_nxt = REQ;
               end
            end
            WAIT: begin
               if (bus.imem_rsp_valid) begin
                  w_state_nxt   = REQ;
                  w_discard_nxt = 1'b0;
               end else begin
                  w_state_nxt   = WAIT;
                  w_discard_nxt = 1'b1;
               end
            end
            HOLD: w_state_nxt = REQ;
         endcase
      end else begin
         unique case (r_state)
            IDLE: w_state_nxt = REQ;
            REQ: begin
               if (bus.imem_req_ready) w_state_nxt = WAIT;
            end
            WAIT: begin
               if (bus.imem_rsp_valid) begin
                  if (r_discard) begin
                     w_discard_nxt = 1'b0;
                     w_state_nxt   = REQ;
                  end else begin
                     w_load      = 1'b1;
                     w_pc_nxt    = r_pc + 32'd4;
                     w_state_nxt = HOLD;
                  end
               end
            end
            HOLD: begin
               if (bus.instr_ready) begin
                  w_clr       = 1'b1;
                  w_state_nxt = REQ;
               end
            end
         endcase
      end
   end

   assign bus.imem_req_valid = (r_state == REQ);
   assign bus.imem_addr      = r_pc;

   fetch_buffer u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (w_load),
      .i_clr     (w_clr),
      .i_data    (bus.imem_rsp_data),
      .i_pc      (r_pc),
      .o_valid   (bus.instr_valid),
      .o_instr   (bus.instr),
      .o_pc      (bus.instr_pc),
      .o_op_code (bus.op_code),
      .o_f3      (bus.f3),
      .o_f7      (bus.f7)
   );

endmodule
